// File: rtl/fft_frame_sequencer.sv
// Frame controller for the FFT path: sequences SPI load -> feed -> core start -> run -> ready,
// with sticky overrun/timeout flags and a completed-frame counter.
module fft_frame_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_loaded,
    input  logic             in_sent,
    input  logic             out_buf_ready,
    input  logic             err_clear,
    output logic             in_enable,
    output logic             core_start,
    output logic             out_clear,
    output logic             frame_ready,
    output logic             busy,
    output logic             overrun,
    output logic             timeout,
    output logic [CNT_W-1:0] frame_count,
    output logic [2:0]       state_dbg
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFeed  = 3'd1,
        StStart = 3'd2,
        StRun   = 3'd3,
        StReady = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               new_frame;
    logic               ovr_set, to_set;
    logic               in_enable_q, core_start_q, out_clear_q, frame_ready_q, busy_q;
    logic               overrun_q, timeout_q;

    // sync2_q is the synchronized level; sync3_q holds its previous value for edge detection
    assign new_frame = sync2_q & ~sync3_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ovr_set = 1'b0;
        to_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (new_frame) begin
                    state_d = StFeed;
                    timer_d = '0;
                end
            end
            StFeed: begin
                ovr_set = new_frame;
                if (timer_q == TimerMax) begin
                    to_set  = 1'b1;
                    state_d = StIdle;
                    timer_d = '0;
                end else if (in_sent) begin
                    state_d = StStart;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStart: begin
                ovr_set = new_frame;
                state_d = StRun;
                timer_d = '0;
            end
            StRun: begin
                ovr_set = new_frame;
                if (timer_q == TimerMax) begin
                    to_set  = 1'b1;
                    state_d = StIdle;
                    timer_d = '0;
                end else if (out_buf_ready) begin
                    state_d = StReady;
                    count_d = count_q + 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StReady: begin
                if (new_frame) begin
                    state_d = StFeed;
                    timer_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            count_q       <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            in_enable_q   <= 1'b0;
            core_start_q  <= 1'b0;
            out_clear_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            sync1_q       <= spi_loaded;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            state_q       <= state_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            in_enable_q   <= (state_d == StFeed);
            out_clear_q   <= (state_d == StFeed) && (state_q != StFeed);
            core_start_q  <= (state_d == StStart);
            frame_ready_q <= (state_d == StReady);
            busy_q        <= (state_d == StFeed) || (state_d == StStart) || (state_d == StRun);
            overrun_q     <= ovr_set | (overrun_q & ~err_clear);
            timeout_q     <= to_set | (timeout_q & ~err_clear);
        end
    end

    assign in_enable   = in_enable_q;
    assign core_start  = core_start_q;
    assign out_clear   = out_clear_q;
    assign frame_ready = frame_ready_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
    assign frame_count = count_q;
    assign state_dbg   = state_q;

endmodule
